// File: rtl/mac_rx_pkt_buffer.sv
// mac_rx_pkt_buffer
//  Captures frames from the tri-mode MAC client receive interface into a circular
//  word RAM and commits only complete frames. Committed frames are replayed, in
//  arrival order, on an AXI4-Stream master. Aborted and oversize frames are dropped.
// Ports
//  mac_clk_i / mac_rst_i     clock, synchronous active-high reset
//  mac_rx*_i, mac_ben_i      MAC receive client interface (inputs)
//  mac_rxrqrd_o              read request to the MAC
//  m_axis_*                  AXI4-Stream master (tdata/tkeep/tlast/tvalid out, tready in)
//  frm_cnt_o / drop_cnt_o    committed / dropped frame counters (wrapping)
//  buf_level_o               words held: committed plus in-capture
module mac_rx_pkt_buffer #(
    parameter int unsigned ADDR_W          = 11,
    parameter int unsigned MAX_FRAME_WORDS = 380,
    parameter int unsigned DESC_DEPTH      = 16
) (
    input  logic              mac_clk_i,
    input  logic              mac_rst_i,
    input  logic [31:0]       mac_rxd_i,
    input  logic [1:0]        mac_ben_i,
    input  logic              mac_rxda_i,
    input  logic              mac_rxsop_i,
    input  logic              mac_rxeop_i,
    input  logic              mac_rxdv_i,
    output logic              mac_rxrqrd_o,
    output logic [31:0]       m_axis_tdata,
    output logic [3:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [15:0]       frm_cnt_o,
    output logic [15:0]       drop_cnt_o,
    output logic [ADDR_W:0]   buf_level_o
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned LVL_W  = ADDR_W + 1;
    localparam int unsigned BL_W   = ADDR_W + 3;
    localparam int unsigned DA_W   = $clog2(DESC_DEPTH);
    localparam int unsigned BEAT_W = 37;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_CAP, W_DISCARD} wr_state_e;

    // storage
    logic [31:0]     ram_q  [DEPTH];
    logic [BL_W-1:0] desc_q [DESC_DEPTH];

    // write side
    wr_state_e         wst_q, wst_d;
    logic [LVL_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] wr_base_q;
    logic [LVL_W-1:0]  cused_q, cused_d;
    logic              rqrd_q;
    logic [15:0]       frm_q, drop_q;
    logic [LVL_W-1:0]  level_q;
    logic [DA_W:0]     desc_wp_q, desc_rp_q;
    logic              ram_we_c, commit_c, drop_c, free_ok_c, desc_full_c, desc_empty_c;
    logic [ADDR_W-1:0] ram_waddr_c;
    logic [LVL_W-1:0]  commit_len_c;
    logic [BL_W-1:0]   commit_blen_c;
    logic [2:0]        last_bytes_c;

    // read side
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0]  rd_left_q, rd_left_d, head_words_c;
    logic [1:0]        tail_q, tail_d, issue_tail_c;
    logic              rd_vld_q, rd_last_q, issue_c, start_c, issue_last_c, pop_c;
    logic [3:0]        rd_keep_q, issue_keep_c;
    logic [31:0]       ram_rdata_q;
    logic [BL_W-1:0]   desc_head_c;
    logic [BEAT_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d, push_beat_c;
    logic [1:0]        occ_q, occ_d;
    logic              tvalid_q;

    function automatic logic [3:0] tail_keep(input logic [1:0] t);
        case (t)
            2'd1:    tail_keep = 4'h1;
            2'd2:    tail_keep = 4'h3;
            2'd3:    tail_keep = 4'h7;
            default: tail_keep = 4'hF;
        endcase
    endfunction

    assign free_ok_c    = (LVL_W'(DEPTH) - cused_q) >= LVL_W'(MAX_FRAME_WORDS);
    assign desc_empty_c = (desc_wp_q == desc_rp_q);
    assign desc_full_c  = (desc_wp_q[DA_W] != desc_rp_q[DA_W]) &&
                          (desc_wp_q[DA_W-1:0] == desc_rp_q[DA_W-1:0]);
    assign last_bytes_c  = (mac_ben_i == 2'b00) ? 3'd4 : {1'b0, mac_ben_i};
    assign commit_blen_c = (BL_W'(commit_len_c - LVL_W'(1)) << 2) + BL_W'(last_bytes_c);

    // Write FSM next-state: capture, commit, abort on stray SOP, drop on overflow
    always_comb begin
        wst_d        = wst_q;
        len_d        = len_q;
        ram_we_c     = 1'b0;
        ram_waddr_c  = wr_base_q + ADDR_W'(len_q);
        commit_c     = 1'b0;
        commit_len_c = '0;
        drop_c       = 1'b0;
        case (wst_q)
            W_IDLE: if (mac_rxda_i && free_ok_c && !desc_full_c) wst_d = W_REQ;
            W_REQ, W_CAP: begin
                if (mac_rxdv_i && mac_rxsop_i) begin
                    // SOP always restarts at the committed pointer; an open frame is lost
                    drop_c      = (wst_q == W_CAP);
                    ram_we_c    = 1'b1;
                    ram_waddr_c = wr_base_q;
                    len_d       = LVL_W'(1);
                    wst_d       = W_CAP;
                    if (mac_rxeop_i) begin
                        commit_c     = 1'b1;
                        commit_len_c = LVL_W'(1);
                        len_d        = '0;
                        wst_d        = W_IDLE;
                    end
                end else if (mac_rxdv_i && (wst_q == W_CAP)) begin
                    if (len_q >= LVL_W'(MAX_FRAME_WORDS)) begin
                        drop_c = 1'b1;
                        len_d  = '0;
                        wst_d  = mac_rxeop_i ? W_IDLE : W_DISCARD;
                    end else begin
                        ram_we_c = 1'b1;
                        len_d    = len_q + LVL_W'(1);
                        if (mac_rxeop_i) begin
                            commit_c     = 1'b1;
                            commit_len_c = len_q + LVL_W'(1);
                            len_d        = '0;
                            wst_d        = W_IDLE;
                        end
                    end
                end
            end
            W_DISCARD: if (mac_rxdv_i && mac_rxeop_i) wst_d = W_IDLE;
            default:   wst_d = W_IDLE;
        endcase
    end

    // Read issue: keep output buffer plus in-flight RAM read within two entries
    always_comb begin
        pop_c        = tvalid_q && m_axis_tready;
        desc_head_c  = desc_q[desc_rp_q[DA_W-1:0]];
        head_words_c = LVL_W'((desc_head_c + BL_W'(3)) >> 2);
        issue_c      = ((rd_left_q != '0) || !desc_empty_c) &&
                       ((3'(occ_q) + 3'(rd_vld_q) - 3'(pop_c)) < 3'd2);
        start_c      = issue_c && (rd_left_q == '0);
        rd_left_d    = rd_left_q;
        tail_d       = tail_q;
        issue_last_c = 1'b0;
        if (start_c) begin
            rd_left_d    = head_words_c - LVL_W'(1);
            tail_d       = desc_head_c[1:0];
            issue_last_c = (head_words_c == LVL_W'(1));
        end else if (issue_c) begin
            rd_left_d    = rd_left_q - LVL_W'(1);
            issue_last_c = (rd_left_q == LVL_W'(1));
        end
        issue_tail_c = start_c ? desc_head_c[1:0] : tail_q;
        issue_keep_c = issue_last_c ? tail_keep(issue_tail_c) : 4'hF;
    end

    // Two-entry output buffer: ent0 drives the stream, ent1 is the skid slot
    always_comb begin
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        occ_d       = occ_q;
        push_beat_c = {rd_last_q, rd_keep_q, ram_rdata_q};
        case ({rd_vld_q, pop_c})
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = push_beat_c;
                else               ent1_d = push_beat_c;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) ent0_d = push_beat_c;
                else begin
                    ent0_d = ent1_q;
                    ent1_d = push_beat_c;
                end
            end
            default: ;
        endcase
        cused_d = cused_q + commit_len_c - LVL_W'(pop_c);
    end

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            wst_q     <= W_IDLE;
            len_q     <= '0;
            wr_base_q <= '0;
            cused_q   <= '0;
            rqrd_q    <= 1'b0;
            frm_q     <= '0;
            drop_q    <= '0;
            level_q   <= '0;
            desc_wp_q <= '0;
            desc_rp_q <= '0;
            rd_ptr_q  <= '0;
            rd_left_q <= '0;
            tail_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_keep_q <= '0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            occ_q     <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            wst_q     <= wst_d;
            len_q     <= len_d;
            wr_base_q <= wr_base_q + ADDR_W'(commit_len_c);
            cused_q   <= cused_d;
            rqrd_q    <= (wst_d != W_IDLE);
            frm_q     <= frm_q + 16'(commit_c);
            drop_q    <= drop_q + 16'(drop_c);
            level_q   <= cused_d + len_d;
            desc_wp_q <= desc_wp_q + (DA_W+1)'(commit_c);
            desc_rp_q <= desc_rp_q + (DA_W+1)'(start_c);
            rd_ptr_q  <= rd_ptr_q + ADDR_W'(issue_c);
            rd_left_q <= rd_left_d;
            tail_q    <= tail_d;
            rd_vld_q  <= issue_c;
            rd_last_q <= issue_last_c;
            rd_keep_q <= issue_keep_c;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            occ_q     <= occ_d;
            tvalid_q  <= (occ_d != 2'd0);
        end
    end

    // Packet RAM and descriptor storage, contents not reset
    always_ff @(posedge mac_clk_i) begin
        if (ram_we_c) ram_q[ram_waddr_c] <= mac_rxd_i;
        if (issue_c)  ram_rdata_q <= ram_q[rd_ptr_q];
        if (commit_c) desc_q[desc_wp_q[DA_W-1:0]] <= commit_blen_c;
    end

    assign mac_rxrqrd_o  = rqrd_q;
    assign m_axis_tdata  = ent0_q[31:0];
    assign m_axis_tkeep  = ent0_q[35:32];
    assign m_axis_tlast  = ent0_q[36];
    assign m_axis_tvalid = tvalid_q;
    assign frm_cnt_o     = frm_q;
    assign drop_cnt_o    = drop_q;
    assign buf_level_o   = level_q;

endmodule

// File: tb/tb_mac_rx_pkt_buffer.sv
// tb_mac_rx_pkt_buffer
//  Directed bench: acts as the MAC client, records AXI-Stream beats and compares
//  them against beats the bench builds from its own frame descriptions.
module tb_mac_rx_pkt_buffer;
    logic        mac_clk_i = 1'b0;
    logic        mac_rst_i = 1'b1;
    logic [31:0] mac_rxd_i = '0;
    logic [1:0]  mac_ben_i = '0;
    logic        mac_rxda_i = 1'b0, mac_rxsop_i = 1'b0, mac_rxeop_i = 1'b0, mac_rxdv_i = 1'b0;
    logic        mac_rxrqrd_o;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [15:0] frm_cnt_o, drop_cnt_o;
    logic [11:0] buf_level_o;

    int tests = 0;
    int errs  = 0;
    int rdy_mode = 0;             // 0: ready high, 1: ready low, 2: random
    int wptr_m = 0;               // expected committed write pointer
    logic [35:0] beat_q [$];      // {sop, eop, ben, data} to drive
    logic [36:0] exp_q  [$];      // {last, keep, data} expected on the stream
    logic [36:0] rcv_q  [$];
    logic        prev_stall = 1'b0;
    logic [36:0] prev_beat = '0;

    mac_rx_pkt_buffer dut (
        .mac_clk_i(mac_clk_i), .mac_rst_i(mac_rst_i), .mac_rxd_i(mac_rxd_i),
        .mac_ben_i(mac_ben_i), .mac_rxda_i(mac_rxda_i), .mac_rxsop_i(mac_rxsop_i),
        .mac_rxeop_i(mac_rxeop_i), .mac_rxdv_i(mac_rxdv_i), .mac_rxrqrd_o(mac_rxrqrd_o),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .frm_cnt_o(frm_cnt_o), .drop_cnt_o(drop_cnt_o), .buf_level_o(buf_level_o)
    );

    always #5 mac_clk_i = ~mac_clk_i;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial forever begin
        @(posedge mac_clk_i); #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor: record handshakes, enforce hold while stalled
    initial forever begin
        @(negedge mac_clk_i);
        if (mac_rst_i) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                tests++;
                if (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== prev_beat) begin
                    errs++;
                    $display("FAIL axis_hold: got v=%b %h, required v=1 %h", m_axis_tvalid,
                             {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, prev_beat);
                end
            end
            if (m_axis_tvalid && m_axis_tready) rcv_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    function automatic logic [3:0] keep_of(input logic [1:0] ben);
        case (ben)
            2'b01:   keep_of = 4'h1;
            2'b10:   keep_of = 4'h3;
            2'b11:   keep_of = 4'h7;
            default: keep_of = 4'hF;
        endcase
    endfunction

    task automatic add_frame(input int n, input logic [1:0] ben, input logic [31:0] base,
                             input bit expect_out, input bit with_eop);
        logic last;
        for (int i = 0; i < n; i++) begin
            last = with_eop && (i == n - 1);
            beat_q.push_back({(i == 0), last, ben, base + 32'(i)});
            if (expect_out) exp_q.push_back({last, last ? keep_of(ben) : 4'hF, base + 32'(i)});
        end
        if (expect_out) wptr_m = (wptr_m + n) % 2048;
    endtask

    task automatic play(input int budget, output bit ok);
        int n = 0;
        mac_rxda_i = 1'b1;
        while (mac_rxrqrd_o !== 1'b1 && n < budget) begin
            @(posedge mac_clk_i); #1;
            n++;
        end
        ok = (mac_rxrqrd_o === 1'b1);
        if (!ok) beat_q.delete();
        while (beat_q.size() > 0) begin
            {mac_rxsop_i, mac_rxeop_i, mac_ben_i, mac_rxd_i} = beat_q.pop_front();
            mac_rxdv_i = 1'b1;
            @(posedge mac_clk_i); #1;
        end
        {mac_rxdv_i, mac_rxsop_i, mac_rxeop_i, mac_rxda_i} = 4'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while (rcv_q.size() < exp_q.size() && n < budget) begin
            @(posedge mac_clk_i); #1;
            n++;
        end
        ok = (rcv_q.size() >= exp_q.size());
        repeat (4) @(posedge mac_clk_i);
        #1;
    endtask

    task automatic do_reset();
        mac_rst_i = 1'b1;
        {mac_rxdv_i, mac_rxsop_i, mac_rxeop_i, mac_rxda_i} = 4'b0;
        repeat (3) @(posedge mac_clk_i);
        #1;
        beat_q.delete(); exp_q.delete(); rcv_q.delete();
        wptr_m = 0;
        mac_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge mac_clk_i);
        tests++;
        if ({mac_rxrqrd_o, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 39'd0) begin
            errs++;
            $display("FAIL reset_outputs: got rq=%b v=%b l=%b k=%h d=%h, required all 0", mac_rxrqrd_o,
                     m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata);
        end
        tests++;
        if ({frm_cnt_o, drop_cnt_o, buf_level_o} !== 44'd0) begin
            errs++;
            $display("FAIL reset_counters: got frm=%0d drop=%0d lvl=%0d, required 0", frm_cnt_o, drop_cnt_o, buf_level_o);
        end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        rdy_mode = 0;
        add_frame(4, 2'b10, 32'h1000_0000, 1, 1);
        play(20, ok);
        tests++;
        if (!ok) begin errs++; $display("FAIL t1_rqrd: rxrqrd never rose, required 1"); end
        tests++;
        if (mac_rxrqrd_o !== 1'b0) begin errs++; $display("FAIL t1_rqrd_drop: got %b, required 0", mac_rxrqrd_o); end
        drain(50, ok);
        tests++;
        if (!ok || rcv_q.size() != exp_q.size()) begin
            errs++; $display("FAIL t1_beats: got %0d beats, required %0d", rcv_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            tests++;
            if (rcv_q[i] !== exp_q[i]) begin errs++; $display("FAIL t1_beat%0d: got %h, required %h", i, rcv_q[i], exp_q[i]); end
        end
        tests++;
        if (rcv_q.size() != 4 || rcv_q[3] !== {1'b1, 4'h3, 32'h1000_0003}) begin
            errs++; $display("FAIL t1_last: got %0d beats, required last {1,3,10000003}", rcv_q.size());
        end
        tests++;
        if (frm_cnt_o !== 16'd1 || buf_level_o !== 12'd0) begin
            errs++; $display("FAIL t1_counts: got frm=%0d lvl=%0d, required 1 0", frm_cnt_o, buf_level_o);
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        add_frame(1, 2'b01, 32'h2000_00AB, 1, 1);
        play(20, ok);
        drain(50, ok);
        tests++;
        if (!ok || rcv_q.size() != 1 || rcv_q[0] !== {1'b1, 4'h1, 32'h2000_00AB}) begin
            errs++; $display("FAIL t2_single: got %0d beats first=%h, required 1 beat %h", rcv_q.size(),
                             (rcv_q.size() > 0) ? rcv_q[0] : 37'd0, {1'b1, 4'h1, 32'h2000_00AB});
        end
        tests++;
        if (frm_cnt_o !== 16'd1) begin errs++; $display("FAIL t2_frm: got %0d, required 1", frm_cnt_o); end
    endtask

    task automatic test_oversize();
        bit ok;
        do_reset();
        add_frame(381, 2'b00, 32'h3000_0000, 0, 1);
        play(20, ok);
        tests++;
        if (!ok || mac_rxrqrd_o !== 1'b0) begin errs++; $display("FAIL t3_rqrd: got ok=%b rqrd=%b, required 1 0", ok, mac_rxrqrd_o); end
        repeat (3) @(posedge mac_clk_i);
        #1;
        tests++;
        if (drop_cnt_o !== 16'd1 || frm_cnt_o !== 16'd0 || buf_level_o !== 12'd0 || rcv_q.size() != 0) begin
            errs++; $display("FAIL t3_drop: got drop=%0d frm=%0d lvl=%0d beats=%0d, required 1 0 0 0",
                             drop_cnt_o, frm_cnt_o, buf_level_o, rcv_q.size());
        end
        add_frame(8, 2'b11, 32'h3100_0000, 1, 1);
        play(20, ok);
        add_frame(390, 2'b00, 32'h3200_0000, 0, 1);
        play(20, ok);
        add_frame(3, 2'b01, 32'h3300_0000, 1, 1);
        play(20, ok);
        drain(100, ok);
        tests++;
        if (!ok || rcv_q.size() != exp_q.size()) begin
            errs++; $display("FAIL t3_beats: got %0d beats, required %0d", rcv_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            tests++;
            if (rcv_q[i] !== exp_q[i]) begin errs++; $display("FAIL t3_beat%0d: got %h, required %h", i, rcv_q[i], exp_q[i]); end
        end
        tests++;
        if (drop_cnt_o !== 16'd2 || frm_cnt_o !== 16'd2) begin
            errs++; $display("FAIL t3_counts: got drop=%0d frm=%0d, required 2 2", drop_cnt_o, frm_cnt_o);
        end
    endtask

    task automatic test_sop_abort();
        bit ok;
        do_reset();
        add_frame(5, 2'b00, 32'h4000_0000, 0, 0);
        add_frame(6, 2'b10, 32'h4100_0000, 1, 1);
        play(20, ok);
        drain(50, ok);
        tests++;
        if (!ok || rcv_q.size() != exp_q.size()) begin
            errs++; $display("FAIL t4_beats: got %0d beats, required %0d", rcv_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            tests++;
            if (rcv_q[i] !== exp_q[i]) begin errs++; $display("FAIL t4_beat%0d: got %h, required %h", i, rcv_q[i], exp_q[i]); end
        end
        tests++;
        if (drop_cnt_o !== 16'd1 || frm_cnt_o !== 16'd1) begin
            errs++; $display("FAIL t4_counts: got drop=%0d frm=%0d, required 1 1", drop_cnt_o, frm_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int hi = 0;
        do_reset();
        rdy_mode = 1;
        for (int f = 0; f < 5; f++) begin
            add_frame(380, 2'(f), 32'h5000_0000 + 32'(f << 16), 1, 1);
            play(20, ok);
            tests++;
            if (!ok) begin errs++; $display("FAIL t5_req%0d: rxrqrd never rose, required 1", f); end
        end
        repeat (3) @(posedge mac_clk_i);
        #1;
        tests++;
        if (buf_level_o !== 12'd1900 || frm_cnt_o !== 16'd5) begin
            errs++; $display("FAIL t5_level: got lvl=%0d frm=%0d, required 1900 5", buf_level_o, frm_cnt_o);
        end
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h5000_0000) begin
            errs++; $display("FAIL t5_head: got v=%b d=%h, required 1 50000000", m_axis_tvalid, m_axis_tdata);
        end
        mac_rxda_i = 1'b1;
        repeat (40) begin
            @(posedge mac_clk_i); #1;
            if (mac_rxrqrd_o) hi++;
        end
        tests++;
        if (hi != 0) begin errs++; $display("FAIL t5_withhold: rxrqrd high %0d cycles, required 0", hi); end
        add_frame(380, 2'b11, 32'h5500_0000, 1, 1);
        rdy_mode = 0;
        play(3000, ok);
        tests++;
        if (!ok) begin errs++; $display("FAIL t5_req6: rxrqrd never rose, required 1"); end
        drain(6000, ok);
        tests++;
        if (!ok || rcv_q.size() != exp_q.size()) begin
            errs++; $display("FAIL t5_beats: got %0d beats, required %0d", rcv_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            tests++;
            if (rcv_q[i] !== exp_q[i]) begin errs++; $display("FAIL t5_beat%0d: got %h, required %h", i, rcv_q[i], exp_q[i]); end
        end
        tests++;
        if (buf_level_o !== 12'd0 || frm_cnt_o !== 16'd6) begin
            errs++; $display("FAIL t5_end: got lvl=%0d frm=%0d, required 0 6", buf_level_o, frm_cnt_o);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int n;
        int nfrm = 0;
        do_reset();
        rdy_mode = 0;
        while (wptr_m != 2046) begin
            n = (2046 - wptr_m > 380) ? 380 : 2046 - wptr_m;
            add_frame(n, 2'b00, 32'h6000_0000 + 32'(nfrm << 16), 1, 1);
            play(1000, ok);
            nfrm++;
        end
        drain(3000, ok);
        rdy_mode = 2;
        add_frame(6, 2'b11, 32'h6F00_0000, 1, 1);
        play(1000, ok);
        drain(500, ok);
        repeat (20) @(posedge mac_clk_i);
        #1;
        tests++;
        if (!ok || rcv_q.size() != exp_q.size()) begin
            errs++; $display("FAIL t6_beats: got %0d beats, required %0d", rcv_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            tests++;
            if (rcv_q[i] !== exp_q[i]) begin errs++; $display("FAIL t6_beat%0d: got %h, required %h", i, rcv_q[i], exp_q[i]); end
        end
        tests++;
        if (buf_level_o !== 12'd0 || frm_cnt_o !== 16'(nfrm + 1)) begin
            errs++; $display("FAIL t6_end: got lvl=%0d frm=%0d, required 0 %0d", buf_level_o, frm_cnt_o, nfrm + 1);
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        do_reset();
        rdy_mode = 1;
        add_frame(4, 2'b00, 32'h7000_0000, 0, 1);
        play(20, ok);
        add_frame(3, 2'b00, 32'h7100_0000, 0, 0);
        play(20, ok);
        tests++;
        if (frm_cnt_o !== 16'd1 || mac_rxrqrd_o !== 1'b1) begin
            errs++; $display("FAIL t7_pre: got frm=%0d rqrd=%b, required 1 1", frm_cnt_o, mac_rxrqrd_o);
        end
        mac_rst_i = 1'b1;
        @(posedge mac_clk_i); #1;
        tests++;
        if ({mac_rxrqrd_o, m_axis_tvalid} !== 2'b00 || {frm_cnt_o, drop_cnt_o, buf_level_o} !== 44'd0) begin
            errs++; $display("FAIL t7_rst: got rq=%b v=%b frm=%0d drop=%0d lvl=%0d, required all 0",
                             mac_rxrqrd_o, m_axis_tvalid, frm_cnt_o, drop_cnt_o, buf_level_o);
        end
        mac_rst_i = 1'b0;
        rdy_mode = 0;
        repeat (20) @(posedge mac_clk_i);
        #1;
        tests++;
        if (rcv_q.size() != 0) begin errs++; $display("FAIL t7_flush: got %0d beats, required 0", rcv_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_oversize();
        test_sop_abort();
        test_backpressure();
        test_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
